// File: rtl/star_finder.sv
// star_finder: raster-scans a WIDTH x HEIGHT frame held in synchronous-read RAM.
// It finds the first lit pixel (the seed) and grows a bounding box downward
// from it, one row at a time. The box is handed to clean_star through the
// goClean/doneClean handshake, and scanning then resumes from the seed.
// Optional clean watchdog: define STAR_FINDER_CLEAN_TIMEOUT_EN.
module star_finder #(
    parameter int xSz     = 3,
    parameter int ySz     = 3,
    parameter int colSz   = 3,
    parameter int addrSz  = 6,
    parameter int WIDTH   = 6,
    parameter int HEIGHT  = 6,
    parameter int THRESH  = 1,
    parameter int cntSz   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              goFind,
    output logic [addrSz-1:0] rdAddress,
    input  logic [colSz-1:0]  rdData,
    output logic              goClean,
    output logic [xSz-1:0]    xLeft,
    output logic [xSz-1:0]    xRight,
    output logic [ySz-1:0]    yTop,
    output logic [ySz-1:0]    yBottom,
    input  logic              doneClean,
    output logic [cntSz-1:0]  starCount,
    output logic              busy,
    output logic              doneFind,
    output logic              errTimeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN_RD, S_SCAN_CHK, S_GROW_RD, S_GROW_CHK,
        S_ROW_END, S_CLEAN_REQ, S_CLEAN_WAIT, S_DONE
    } state_t;

    localparam logic [xSz-1:0] X_LAST = xSz'(WIDTH - 1);
    localparam logic [ySz-1:0] Y_LAST = ySz'(HEIGHT - 1);

    state_t             r_state;
    logic [xSz-1:0]     r_x, r_c, r_hi, r_rowMin, r_rowMax;
    logic [ySz-1:0]     r_y, r_r;
    logic               r_rowLit;
    logic [xSz-1:0]     r_xLeft, r_xRight;
    logic [ySz-1:0]     r_yTop, r_yBottom;
    logic [cntSz-1:0]   r_cnt;
    logic               r_busy, r_goClean, r_doneFind;

`ifdef STAR_FINDER_CLEAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      r_tmo;
    logic               r_err;
`endif

    logic               w_lit, w_chase, w_grow;
    logic [xSz-1:0]     w_hiNext, w_newL, w_newR, w_col;
    logic [ySz-1:0]     w_row;

    // Left neighbour of a column, clamped at column 0.
    function automatic logic [xSz-1:0] f_lo(input logic [xSz-1:0] l);
        return (l == '0) ? '0 : l - xSz'(1);
    endfunction

    // Right neighbour of a column, clamped at the last column.
    function automatic logic [xSz-1:0] f_hi(input logic [xSz-1:0] r);
        return (r == X_LAST) ? r : r + xSz'(1);
    endfunction

    assign w_lit    = (rdData >= colSz'(THRESH));
    // A lit pixel at the current right limit pushes the limit one further right.
    assign w_chase  = w_lit && (r_c == r_hi) && (r_hi != X_LAST);
    assign w_hiNext = w_chase ? r_hi + xSz'(1) : r_hi;
    assign w_newL   = (r_rowMin < r_xLeft)  ? r_rowMin : r_xLeft;
    assign w_newR   = (r_rowMax > r_xRight) ? r_rowMax : r_xRight;

    // The read address follows the grow cursor while growing, otherwise the scan pointer.
    assign w_grow    = (r_state == S_GROW_RD) || (r_state == S_GROW_CHK);
    assign w_row     = w_grow ? r_r : r_y;
    assign w_col     = w_grow ? r_c : r_x;
    assign rdAddress = addrSz'(w_row) * addrSz'(WIDTH) + addrSz'(w_col);

    assign goClean   = r_goClean;
    assign xLeft     = r_xLeft;
    assign xRight    = r_xRight;
    assign yTop      = r_yTop;
    assign yBottom   = r_yBottom;
    assign starCount = r_cnt;
    assign busy      = r_busy;
    assign doneFind  = r_doneFind;
`ifdef STAR_FINDER_CLEAN_TIMEOUT_EN
    assign errTimeout = r_err;
`else
    assign errTimeout = 1'b0;
`endif

    // Main controller: scan, grow, clean handshake, with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_c        <= '0;
            r_hi       <= '0;
            r_r        <= '0;
            r_rowLit   <= 1'b0;
            r_rowMin   <= '0;
            r_rowMax   <= '0;
            r_xLeft    <= '0;
            r_xRight   <= '0;
            r_yTop     <= '0;
            r_yBottom  <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_goClean  <= 1'b0;
            r_doneFind <= 1'b0;
`ifdef STAR_FINDER_CLEAN_TIMEOUT_EN
            r_tmo      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_goClean  <= 1'b0;
            r_doneFind <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (goFind) begin
                        r_state <= S_SCAN_RD;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
`ifdef STAR_FINDER_CLEAN_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_SCAN_RD: r_state <= S_SCAN_CHK;
                S_SCAN_CHK: begin
                    if (w_lit) begin
                        r_xLeft   <= r_x;
                        r_xRight  <= r_x;
                        r_yTop    <= r_y;
                        r_yBottom <= r_y;
                        r_r       <= r_y;
                        r_c       <= f_lo(r_x);
                        r_hi      <= f_hi(r_x);
                        r_rowLit  <= 1'b0;
                        r_state   <= S_GROW_RD;
                    end else if ((r_x == X_LAST) && (r_y == Y_LAST)) begin
                        r_state    <= S_DONE;
                        r_doneFind <= 1'b1;
                    end else begin
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + ySz'(1);
                        end else begin
                            r_x <= r_x + xSz'(1);
                        end
                        r_state <= S_SCAN_RD;
                    end
                end
                S_GROW_RD: r_state <= S_GROW_CHK;
                S_GROW_CHK: begin
                    // Columns are visited left to right, so the first lit one is the row minimum.
                    if (w_lit) begin
                        if (!r_rowLit) r_rowMin <= r_c;
                        r_rowMax <= r_c;
                        r_rowLit <= 1'b1;
                    end
                    r_hi <= w_hiNext;
                    if (r_c != w_hiNext) begin
                        r_c     <= r_c + xSz'(1);
                        r_state <= S_GROW_RD;
                    end else begin
                        r_state <= S_ROW_END;
                    end
                end
                S_ROW_END: begin
                    if (r_rowLit && (r_r != Y_LAST)) begin
                        r_xLeft   <= w_newL;
                        r_xRight  <= w_newR;
                        r_yBottom <= r_r;
                        r_r       <= r_r + ySz'(1);
                        r_c       <= f_lo(w_newL);
                        r_hi      <= f_hi(w_newR);
                        r_rowLit  <= 1'b0;
                        r_state   <= S_GROW_RD;
                    end else begin
                        if (r_rowLit) begin
                            r_xLeft   <= w_newL;
                            r_xRight  <= w_newR;
                            r_yBottom <= r_r;
                        end
                        r_goClean <= 1'b1;
                        r_state   <= S_CLEAN_REQ;
                    end
                end
                S_CLEAN_REQ: begin
`ifdef STAR_FINDER_CLEAN_TIMEOUT_EN
                    r_tmo   <= TW'(1);
`endif
                    r_state <= S_CLEAN_WAIT;
                end
                S_CLEAN_WAIT: begin
                    // The scan pointer still sits on the seed; once cleaned it reads dark.
                    if (doneClean) begin
                        if (r_cnt != '1) r_cnt <= r_cnt + cntSz'(1);
                        r_state <= S_SCAN_RD;
                    end
`ifdef STAR_FINDER_CLEAN_TIMEOUT_EN
                    else if (r_tmo >= TW'(TIMEOUT)) begin
                        r_err      <= 1'b1;
                        r_doneFind <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
